bcd_to_binary: RTL and testbench
================================

BCD_TO_BINARY -- requirements
Module: bcd_to_binary

Interface
REQ-001 The block SHALL have no parameters; all widths come from constants in the shared package (REQ-027).
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  conversion request; sampled only while busy=0.
REQ-005 bcd_in1  input  4  hundreds digit.
REQ-006 bcd_in2  input  4  tens digit.
REQ-007 bcd_in3  input  4  ones digit.
REQ-008 binary_out  output  10  registered binary result, 0..999.
REQ-009 busy  output  1  high while a conversion is in progress.
REQ-010 done  output  1  one-cycle pulse when a request completes, whether it is a result or an error.
REQ-011 err  output  1  high when the last accepted request contained a digit greater than 9.

Function
REQ-012 The FSM SHALL have the states IDLE and CONV; busy=1 exactly in CONV.
REQ-013 In IDLE, start=1 with all digits <=9 SHALL capture the following into a 22-bit shift register {bcd[11:0], bin[9:0]}:
  - bcd = {bcd_in1,bcd_in2,bcd_in3}
  - bin = 0
  - iteration counter = 0
  - err cleared to 0
  - next state = CONV
REQ-014 Each CONV cycle SHALL perform one reverse double-dabble iteration:
  - shift the 22-bit register right by 1, so that bcd[0] enters bin[9];
  - then subtract 3 from each 4-bit BCD digit that is >=8.
REQ-015 After the 10th iteration edge:
  - binary_out SHALL load bin;
  - done SHALL be 1 for the following cycle;
  - state SHALL return to IDLE.
REQ-016 Latency SHALL be exactly 10 cycles from the start-accepting edge to the edge that raises done; throughput SHALL be one conversion per 11 cycles.
REQ-017 start while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-018 start=1 during the cycle in which done=1 SHALL be accepted, because the state is already IDLE.
REQ-019 In IDLE, start=1 with any digit >9 SHALL NOT enter CONV. Instead:
  - err SHALL be set to 1;
  - done SHALL pulse on the next cycle;
  - binary_out SHALL be set to 0.
REQ-020 err SHALL hold its value until the next accepted start.
REQ-021 binary_out SHALL hold its value between completions.
REQ-022 Input digits SHALL be sampled only at the accepting edge; input changes during CONV SHALL have no effect.
REQ-023 All arithmetic SHALL be unsigned. Digit correction SHALL be 4-bit modulo, and is never negative because it applies only when the digit is >=8.

Reset
REQ-024 rst=1 SHALL immediately force the following, regardless of clk:
  - state to IDLE
  - busy=0, done=0, err=0
  - binary_out=0
  - shift register and counter to 0
REQ-025 rst asserted mid-conversion SHALL abort the conversion with no done pulse; the first start after deassertion SHALL behave as a fresh request.
REQ-026 Deassertion of rst SHALL be synchronous-safe: the first start SHALL be sampled no earlier than the first clk edge after rst falls.

Structure
REQ-027 A shared package SHALL hold:
  - BCD_DIGIT_W=4
  - NUM_DIGITS=3
  - BIN_W=10
  - ITERATIONS=10
  - the FSM state enum (IDLE, CONV)
REQ-028 A combinational sub-module bcd_digit_adjust SHALL map a 4-bit digit d to (d>=8 ? d-3 : d) and SHALL be instantiated once per digit.
REQ-029 The iteration counter SHALL be 4 bits wide, with terminal value ITERATIONS-1.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
  - Digits 9,9,9 then start pulse: binary_out=999 and done=1 exactly 10 cycles after the accepting edge; err=0.
  - Digits 2,5,5 then start: binary_out=255. Also an exhaustive sweep 000..999, where each result SHALL equal 100*d1+10*d2+d3.
  - Digits 0,0,0: binary_out=0. Then digits 1,A,0: err=1, done pulses after 1 cycle, binary_out=0, busy stays 0.
  - Start held high for 30 cycles with digits 1,2,3: results at cycles 10, 21, 32 (back-to-back acceptance in done cycles); start pulses in CONV are ignored.
  - rst raised at iteration 5 of a 4,5,6 conversion: busy=0 and binary_out=0 immediately, with no done pulse. Then a 7,8,9 request completes with 789.

Source files
------------

// File: rtl/bcd_to_binary_pkg.sv
// rtl/bcd_to_binary_pkg.sv - shared widths, FSM states and digit helpers for the BCD-to-binary converter
package bcd_to_binary_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int NUM_DIGITS  = 3;
  localparam int BIN_W       = 10;
  localparam int ITERATIONS  = 10;

  localparam int BCD_W = NUM_DIGITS * BCD_DIGIT_W;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = 4;

  localparam logic [CNT_W-1:0]       LAST_ITER      = CNT_W'(ITERATIONS - 1);
  localparam logic [BCD_DIGIT_W-1:0] DIGIT_MAX      = 4'd9;
  localparam logic [BCD_DIGIT_W-1:0] DIGIT_ADJ_MIN  = 4'd8;
  localparam logic [BCD_DIGIT_W-1:0] DIGIT_ADJ_SUB  = 4'd3;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  // True when every 4-bit field of the packed digit vector is a legal decimal digit.
  function automatic logic bcd_valid(input logic [BCD_W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[i*BCD_DIGIT_W +: BCD_DIGIT_W] > DIGIT_MAX) begin
        ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// rtl/bcd_digit_adjust.sv - reverse double-dabble correction for one BCD digit
module bcd_digit_adjust
  import bcd_to_binary_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d,
  output logic [BCD_DIGIT_W-1:0] q
);

  // A digit that reached 8 after the right shift absorbed a half-ten borrow; pull it back by 3.
  assign q = (d >= DIGIT_ADJ_MIN) ? (d - DIGIT_ADJ_SUB) : d;

endmodule

// File: rtl/bcd_to_binary.sv
// rtl/bcd_to_binary.sv - three-digit BCD to 10-bit binary converter, one shift-and-correct step per cycle
module bcd_to_binary
  import bcd_to_binary_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [BCD_DIGIT_W-1:0] bcd_in1,
  input  logic [BCD_DIGIT_W-1:0] bcd_in2,
  input  logic [BCD_DIGIT_W-1:0] bcd_in3,
  output logic [BIN_W-1:0]       binary_out,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  state_t           state;
  logic [SR_W-1:0]  sr;
  logic [SR_W-1:0]  sr_shift;
  logic [SR_W-1:0]  sr_next;
  logic [CNT_W-1:0] cnt;
  logic [BCD_W-1:0] bcd_cat;
  logic             digits_ok;

  assign bcd_cat   = {bcd_in1, bcd_in2, bcd_in3};
  assign digits_ok = bcd_valid(bcd_cat);

  // Register layout is {bcd, bin}; the shift moves the lowest BCD bit into the top of bin.
  assign sr_shift = sr >> 1;
  assign sr_next[BIN_W-1:0] = sr_shift[BIN_W-1:0];

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .d (sr_shift[BIN_W + g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .q (sr_next [BIN_W + g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sr         <= '0;
      cnt        <= '0;
      binary_out <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (digits_ok) begin
              sr    <= {bcd_cat, {BIN_W{1'b0}}};
              cnt   <= '0;
              err   <= 1'b0;
              busy  <= 1'b1;
              state <= CONV;
            end else begin
              // Bad digit: report immediately without ever entering CONV.
              err        <= 1'b1;
              done       <= 1'b1;
              binary_out <= '0;
            end
          end
        end
        CONV: begin
          sr  <= sr_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_ITER) begin
            binary_out <= sr_next[BIN_W-1:0];
            done       <= 1'b1;
            busy       <= 1'b0;
            cnt        <= '0;
            state      <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_binary.sv
// tb/tb_bcd_to_binary.sv - self-checking bench for bcd_to_binary against an arithmetic reference
module tb_bcd_to_binary;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] bcd_in1;
  logic [3:0] bcd_in2;
  logic [3:0] bcd_in3;
  logic [9:0] binary_out;
  logic       busy;
  logic       done;
  logic       err;

  int total;
  int bad;

  bcd_to_binary dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bcd_in1    (bcd_in1),
    .bcd_in2    (bcd_in2),
    .bcd_in3    (bcd_in3),
    .binary_out (binary_out),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Valid request: expects the decimal value after exactly 10 cycles; digits may be scrambled mid-flight.
  task automatic run_conv(input int d1, input int d2, input int d3, input bit scramble);
    int lat;
    int exp_val;
    exp_val = 100*d1 + 10*d2 + d3;
    bcd_in1 = 4'(d1);
    bcd_in2 = 4'(d2);
    bcd_in3 = 4'(d3);
    start   = 1'b1;
    step();
    start = 1'b0;
    chk("accept_busy", busy, 1);
    chk("accept_err_clear", err, 0);
    lat = 0;
    while (!done && lat < 20) begin
      if (scramble) begin
        bcd_in1 = 4'($urandom_range(0, 15));
        bcd_in2 = 4'($urandom_range(0, 15));
        bcd_in3 = 4'($urandom_range(0, 15));
        start   = 1'($urandom_range(0, 1));
      end
      step();
      lat++;
    end
    start = 1'b0;
    chk("latency", lat, 10);
    chk("result", binary_out, exp_val);
    chk("err_after_valid", err, 0);
    chk("busy_at_done", busy, 0);
  endtask

  // Invalid request: done next cycle, err set, result cleared, never busy.
  task automatic run_err(input int d1, input int d2, input int d3);
    bcd_in1 = 4'(d1);
    bcd_in2 = 4'(d2);
    bcd_in3 = 4'(d3);
    start   = 1'b1;
    step();
    start = 1'b0;
    chk("err_done", done, 1);
    chk("err_flag", err, 1);
    chk("err_busy", busy, 0);
    chk("err_result", binary_out, 0);
    step();
    chk("err_done_clear", done, 0);
    chk("err_hold", err, 1);
    chk("err_busy_idle", busy, 0);
  endtask

  initial begin
    int d1, d2, d3;
    int done_cycles[$];
    int t;
    bit exp_done;

    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    start   = 1'b0;
    bcd_in1 = '0;
    bcd_in2 = '0;
    bcd_in3 = '0;

    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_out", binary_out, 0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);

    run_conv(9, 9, 9, 1'b0);
    run_conv(2, 5, 5, 1'b0);
    step();
    run_conv(0, 0, 0, 1'b0);
    run_err(1, 10, 0);

    // Exhaustive sweep of every legal three-digit value.
    for (int v = 0; v < 1000; v++) begin
      run_conv(v / 100, (v / 10) % 10, v % 10, 1'b0);
    end

    // Random mix of legal and illegal requests with inputs disturbed during conversion.
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        d1 = $urandom_range(0, 15);
        d2 = $urandom_range(0, 15);
        d3 = $urandom_range(10, 15);
        if ($urandom_range(0, 1) == 1) begin
          t  = d1;
          d1 = d3;
          d3 = t;
        end
      end else begin
        d1 = $urandom_range(0, 9);
        d2 = $urandom_range(0, 9);
        d3 = $urandom_range(0, 9);
      end
      if (d1 > 9 || d2 > 9 || d3 > 9) begin
        run_err(d1, d2, d3);
      end else begin
        run_conv(d1, d2, d3, 1'b1);
      end
      repeat ($urandom_range(0, 2)) step();
    end

    // Start held for 30 edges: acceptances every 11 cycles while start is high.
    step();
    t = 0;
    while (t < 30) begin
      done_cycles.push_back(t + 10);
      t += 11;
    end
    bcd_in1 = 4'd1;
    bcd_in2 = 4'd2;
    bcd_in3 = 4'd3;
    start   = 1'b1;
    step();
    for (int c = 1; c <= 40; c++) begin
      step();
      if (c == 29) start = 1'b0;
      exp_done = 1'b0;
      foreach (done_cycles[i]) if (done_cycles[i] == c) exp_done = 1'b1;
      chk($sformatf("held_done_c%0d", c), done, exp_done);
      if (exp_done) chk($sformatf("held_result_c%0d", c), binary_out, 123);
      if (c == 5) chk("held_busy_c5", busy, 1);
    end

    // Reset during iteration 5 of a 4,5,6 conversion.
    bcd_in1 = 4'd4;
    bcd_in2 = 4'd5;
    bcd_in3 = 4'd6;
    start   = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    chk("pre_rst_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_out", binary_out, 0);
    chk("midrst_done", done, 0);
    chk("midrst_err", err, 0);
    step();
    step();
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step();
      chk("post_rst_no_done", done, 0);
    end
    run_conv(7, 8, 9, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
